// File: rtl/cw305_pmul_operand_stager.sv
// cw305_pmul_operand_stager
// Register-side staging for the P-256 point-multiply core: assembles byte
// writes into K/GX/GY, launches the core, captures RX/RY and serves byte reads.
// Optional build macro: PMUL_OPERAND_CHECK_EN refuses launches with K == 0 or
// with GX == GY == 0 (sets the error flag instead of starting the core).
module cw305_pmul_operand_stager #(
  parameter int         pBYTECNT_SIZE   = 8,
  parameter int         pTIMEOUT_CYCLES = 2000000,
  // Register map; must match the REG_CRYPT_* values used by the USB decoder
  parameter logic [7:0] pREG_CRYPT_K    = 8'h01,
  parameter logic [7:0] pREG_CRYPT_GX   = 8'h02,
  parameter logic [7:0] pREG_CRYPT_GY   = 8'h03,
  parameter logic [7:0] pREG_CRYPT_RX   = 8'h04,
  parameter logic [7:0] pREG_CRYPT_RY   = 8'h05,
  parameter logic [7:0] pREG_CRYPT_GO   = 8'h06
) (
  input  logic                     crypto_clk,
  input  logic                     reset_n,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datai,
  input  logic                     reg_write,
  input  logic                     reg_read,
  output logic [7:0]               reg_datao,
  input  logic                     exttrigger_in,
  output logic [255:0]             O_k,
  output logic [255:0]             O_gx,
  output logic [255:0]             O_gy,
  output logic                     O_start,
  input  logic [255:0]             I_rx,
  input  logic [255:0]             I_ry,
  input  logic                     I_done,
  output logic                     O_busy,
  output logic                     O_trigger
);

  // The counter tracks cycles since the launch cycle (launch cycle = 0), so
  // the core gets exactly pTIMEOUT_CYCLES cycles of busy before the abort.
  localparam int               CNT_W    = (pTIMEOUT_CYCLES > 2) ? $clog2(pTIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pTIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [255:0]     k_reg, gx_reg, gy_reg, rx_reg, ry_reg;
  logic             busy, start, err, wwb, ext_d;
  logic [7:0]       datao;
  logic [7:0]       rd_byte;

  logic             in_range;
  logic [4:0]       bidx;
  logic [7:0]       bit_base;
  logic             op_addr;
  logic             op_wr_ok;
  logic             go_req;
  logic             ext_rise;
  logic             start_req;
  logic             refuse;

  assign in_range  = (32'(reg_bytecnt) < 32'd32);
  assign bidx      = reg_bytecnt[4:0];
  assign bit_base  = {bidx, 3'b000};
  assign op_addr   = (reg_address == pREG_CRYPT_K) ||
                     (reg_address == pREG_CRYPT_GX) ||
                     (reg_address == pREG_CRYPT_GY);
  assign op_wr_ok  = reg_write && op_addr && in_range && !busy;
  assign go_req    = reg_write && (reg_address == pREG_CRYPT_GO) && reg_datai[0];
  assign ext_rise  = exttrigger_in && !ext_d;
  // A GO write and a trigger edge in the same cycle merge into one request
  assign start_req = go_req || ext_rise;

`ifdef PMUL_OPERAND_CHECK_EN
  assign refuse = (k_reg == '0) || ((gx_reg == '0) && (gy_reg == '0));
`else
  assign refuse = 1'b0;
`endif

  // Byte-wise operand staging; writes are blocked while the core is running
  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg  <= '0;
      gx_reg <= '0;
      gy_reg <= '0;
    end else if (op_wr_ok) begin
      case (reg_address)
        pREG_CRYPT_K:  k_reg[bit_base +: 8]  <= reg_datai;
        pREG_CRYPT_GX: gx_reg[bit_base +: 8] <= reg_datai;
        pREG_CRYPT_GY: gy_reg[bit_base +: 8] <= reg_datai;
        default: ;
      endcase
    end
  end

  // Read mux: operand/result bytes, status on GO, zero for anything else
  always_comb begin
    rd_byte = 8'h00;
    case (reg_address)
      pREG_CRYPT_K:  if (in_range) rd_byte = k_reg[bit_base +: 8];
      pREG_CRYPT_GX: if (in_range) rd_byte = gx_reg[bit_base +: 8];
      pREG_CRYPT_GY: if (in_range) rd_byte = gy_reg[bit_base +: 8];
      pREG_CRYPT_RX: if (in_range) rd_byte = rx_reg[bit_base +: 8];
      pREG_CRYPT_RY: if (in_range) rd_byte = ry_reg[bit_base +: 8];
      pREG_CRYPT_GO: rd_byte = {5'b00000, wwb, err, busy};
      default: ;
    endcase
  end

  // Registered read data, one cycle after the read strobe
  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      datao <= 8'h00;
    end else if (reg_read) begin
      datao <= rd_byte;
    end
  end

  // Launch/run/capture control with watchdog; all control outputs registered
  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      start  <= 1'b0;
      err    <= 1'b0;
      wwb    <= 1'b0;
      ext_d  <= 1'b0;
      rx_reg <= '0;
      ry_reg <= '0;
    end else begin
      start <= 1'b0;
      ext_d <= exttrigger_in;
      // Any operand write attempted while busy is flagged until the next launch
      if (reg_write && op_addr && busy) begin
        wwb <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            if (refuse) begin
              err <= 1'b1;
            end else begin
              state <= LAUNCH;
              start <= 1'b1;
              busy  <= 1'b1;
              err   <= 1'b0;
              wwb   <= 1'b0;
              cnt   <= '0;
            end
          end
        end
        LAUNCH: begin
          state <= RUN;
          cnt   <= cnt + CNT_W'(1);
        end
        RUN: begin
          // Completion beats both the watchdog and any new start request
          if (I_done) begin
            rx_reg <= I_rx;
            ry_reg <= I_ry;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign O_k       = k_reg;
  assign O_gx      = gx_reg;
  assign O_gy      = gy_reg;
  assign O_start   = start;
  assign O_busy    = busy;
  assign O_trigger = busy;
  assign reg_datao = datao;

endmodule

// File: tb/tb_cw305_pmul_operand_stager.sv
// Testbench for cw305_pmul_operand_stager (watchdog shortened to 16 cycles).
// Honors PMUL_OPERAND_CHECK_EN when the design is built with it.
module tb_cw305_pmul_operand_stager;

  localparam int         T    = 16;
  localparam logic [7:0] A_K  = 8'h01;
  localparam logic [7:0] A_GX = 8'h02;
  localparam logic [7:0] A_GY = 8'h03;
  localparam logic [7:0] A_RX = 8'h04;
  localparam logic [7:0] A_RY = 8'h05;
  localparam logic [7:0] A_GO = 8'h06;

  localparam logic [255:0] K_VAL  = 256'h70a12c2d_e3c4b5a6_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_11223344_3452b38a;
  localparam logic [255:0] GX_VAL = 256'h6b17d1f2_e12c4247_f8bce6e5_63a440f2_77037d81_2deb33a0_f4a13945_d898c296;
  localparam logic [255:0] GY_VAL = 256'h4fe342e2_fe1a7f9b_8ee7eb4a_7c0f9e16_2bce3357_6b315ece_cbb64068_37bf51f5;
  localparam logic [255:0] RX_VAL = 256'h8101ece4_7464a6ea_d70f6a2b_1f4c8c7e_9a3d2b10_55c6e0f1_23a5b7c9_f26680a8;
  localparam logic [255:0] RY_VAL = 256'hd8a12ba6_1d4c8e3a_77b0f5c2_9e6a0d14_3b8f7c21_a4e5960d_5c1f2e7b_36c0c3a9;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   reg_address = 8'h00;
  logic [7:0]   reg_bytecnt = 8'h00;
  logic [7:0]   reg_datai = 8'h00;
  logic         reg_write = 1'b0;
  logic         reg_read = 1'b0;
  logic [7:0]   reg_datao;
  logic         exttrigger_in = 1'b0;
  logic [255:0] O_k, O_gx, O_gy;
  logic         O_start;
  logic [255:0] I_rx = '0;
  logic [255:0] I_ry = '0;
  logic         I_done = 1'b0;
  logic         O_busy;
  logic         O_trigger;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cnt = 0;

  cw305_pmul_operand_stager #(
    .pBYTECNT_SIZE(8),
    .pTIMEOUT_CYCLES(T)
  ) dut (
    .crypto_clk(clk),
    .reset_n(reset_n),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .reg_datai(reg_datai),
    .reg_write(reg_write),
    .reg_read(reg_read),
    .reg_datao(reg_datao),
    .exttrigger_in(exttrigger_in),
    .O_k(O_k),
    .O_gx(O_gx),
    .O_gy(O_gy),
    .O_start(O_start),
    .I_rx(I_rx),
    .I_ry(I_ry),
    .I_done(I_done),
    .O_busy(O_busy),
    .O_trigger(O_trigger)
  );

  always #5 clk = ~clk;

  // Count launch pulses, sampled mid-cycle
  always @(negedge clk) if (O_start === 1'b1) start_cnt++;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation got=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         do_write;
    logic [7:0] addr;
    logic [7:0] bc;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  // Behavioural register-file model used by the randomized phase
  logic [255:0] m_k, m_gx, m_gy, m_rx, m_ry;
  logic         m_err, m_wwb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    reg_address = a;
    reg_bytecnt = b;
    reg_datai   = d;
    reg_write   = 1'b1;
    tick();
    reg_write   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] b, output logic [7:0] d);
    reg_address = a;
    reg_bytecnt = b;
    reg_read    = 1'b1;
    tick();
    d           = reg_datao;
    reg_read    = 1'b0;
  endtask

  task automatic wr_word(input logic [7:0] a, input logic [255:0] w);
    for (int i = 0; i < 32; i++) wr(a, 8'(i), w[8*i +: 8]);
  endtask

  task automatic rd_word(input logic [7:0] a, output logic [255:0] w);
    logic [7:0] d;
    for (int i = 0; i < 32; i++) begin
      rd(a, 8'(i), d);
      w[8*i +: 8] = d;
    end
  endtask

  task automatic pulse_done(input logic [255:0] rx, input logic [255:0] ry);
    I_rx   = rx;
    I_ry   = ry;
    I_done = 1'b1;
    tick();
    I_done = 1'b0;
  endtask

  task automatic do_reset();
    reg_write = 1'b0;
    reg_read = 1'b0;
    I_done = 1'b0;
    exttrigger_in = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a, input int bc);
    if (a == A_GO) return {5'b0, m_wwb, m_err, 1'b0};
    if (bc >= 32) return 8'h00;
    case (a)
      A_K:  return m_k[8*bc +: 8];
      A_GX: return m_gx[8*bc +: 8];
      A_GY: return m_gy[8*bc +: 8];
      A_RX: return m_rx[8*bc +: 8];
      A_RY: return m_ry[8*bc +: 8];
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    vec_t         vecs[12];
    logic [7:0]   d;
    logic [255:0] w;
    int           s;
    int           n;

    // ---------------- reset state ----------------
    tick();
    chk("reset_O_k", O_k, '0);
    chk("reset_start_busy_trig", {O_start, O_busy, O_trigger}, 3'b000);
    chk("reset_datao", reg_datao, 8'h00);
    reset_n = 1'b1;
    tick();

    // ---------------- table-driven register access in IDLE ----------------
    vecs[0]  = '{1'b1, A_K,   8'd0,   8'hAA, 8'hAA};
    vecs[1]  = '{1'b1, A_K,   8'd31,  8'h55, 8'h55};
    vecs[2]  = '{1'b1, A_K,   8'd32,  8'h77, 8'h00};
    vecs[3]  = '{1'b0, A_K,   8'd0,   8'h00, 8'hAA};
    vecs[4]  = '{1'b1, A_GX,  8'd5,   8'h3C, 8'h3C};
    vecs[5]  = '{1'b1, A_GY,  8'd17,  8'hC3, 8'hC3};
    vecs[6]  = '{1'b0, A_GX,  8'd17,  8'h00, 8'h00};
    vecs[7]  = '{1'b1, A_RX,  8'd0,   8'h99, 8'h00};
    vecs[8]  = '{1'b0, 8'hEE, 8'd0,   8'h00, 8'h00};
    vecs[9]  = '{1'b0, A_GO,  8'd0,   8'h00, 8'h00};
    vecs[10] = '{1'b1, A_GY,  8'd200, 8'h11, 8'h00};
    vecs[11] = '{1'b0, A_GY,  8'd17,  8'h00, 8'hC3};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_write) wr(vecs[i].addr, vecs[i].bc, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].bc, d);
      chk($sformatf("vec%0d_read", i), d, vecs[i].exp);
    end

    // ---------------- basic launch and capture ----------------
    wr_word(A_K, K_VAL);
    wr_word(A_GX, GX_VAL);
    wr_word(A_GY, GY_VAL);
    chk("operand_k", O_k, K_VAL);
    chk("operand_gx", O_gx, GX_VAL);
    chk("operand_gy", O_gy, GY_VAL);
    s = start_cnt;
    wr(A_GO, 8'd0, 8'h01);
    chk("launch_start_busy_trig", {O_start, O_busy, O_trigger}, 3'b111);
    tick();
    chk("launch_start_one_cycle", {O_start, O_busy}, 2'b01);
    rd(A_GO, 8'd0, d);
    chk("status_running", d, 8'h01);
    pulse_done(RX_VAL, RY_VAL);
    chk("busy_after_done", O_busy, 1'b0);
    rd(A_GO, 8'd0, d);
    chk("status_after_done", d, 8'h00);
    rd_word(A_RX, w);
    chk("rx_readback", w, RX_VAL);
    rd_word(A_RY, w);
    chk("ry_readback", w, RY_VAL);
    chk("basic_launch_count", start_cnt - s, 1);

    // ---------------- busy protection ----------------
    s = start_cnt;
    wr(A_GO, 8'd0, 8'h01);
    wr(A_K, 8'd0, 8'hFF);
    wr(A_GO, 8'd0, 8'h01);
    rd(A_GO, 8'd0, d);
    chk("status_wwb_busy", d, 8'h05);
    chk("k_held_while_busy", O_k, K_VAL);
    pulse_done(RX_VAL, RY_VAL);
    rd(A_GO, 8'd0, d);
    chk("wwb_sticky_after_done", d, 8'h04);
    rd(A_K, 8'd0, d);
    chk("k_byte0_unchanged", d, 8'h8a);
    chk("busy_go_dropped", start_cnt - s, 1);

    // ---------------- timeout ----------------
    wr(A_GO, 8'd0, 8'h01);
    chk("timeout_launch", O_start, 1'b1);
    n = 0;
    while (O_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    // Busy covers the launch cycle plus the remaining watchdog cycles: T in total
    chk("timeout_busy_cycles", n, T);
    rd(A_GO, 8'd0, d);
    chk("status_timeout", d, 8'h02);
    rd(A_RX, 8'd0, d);
    chk("rx_kept_on_timeout", d, 8'ha8);
    // Relaunch clears err; I_done in the very last watchdog cycle is a completion
    wr(A_GO, 8'd0, 8'h01);
    chk("relaunch_start", O_start, 1'b1);
    rd(A_GO, 8'd0, d);
    chk("relaunch_status", d, 8'h01);
    for (int i = 0; i < T - 2; i++) tick();
    chk("still_busy_last_cycle", O_busy, 1'b1);
    pulse_done(RY_VAL, RX_VAL);
    rd(A_GO, 8'd0, d);
    chk("done_in_last_cycle_status", d, 8'h00);
    rd(A_RX, 8'd0, d);
    chk("done_in_last_cycle_rx", d, 8'ha9);

    // ---------------- GO together with I_done ----------------
    s = start_cnt;
    wr(A_GO, 8'd0, 8'h01);
    tick();
    tick();
    I_rx = RX_VAL;
    I_ry = RY_VAL;
    I_done = 1'b1;
    wr(A_GO, 8'd0, 8'h01);
    I_done = 1'b0;
    chk("go_with_done_busy", O_busy, 1'b0);
    tick();
    chk("go_with_done_no_start", {O_start, O_busy}, 2'b00);
    rd(A_RX, 8'd0, d);
    chk("go_with_done_rx", d, 8'ha8);
    chk("go_with_done_count", start_cnt - s, 1);

    // ---------------- exttrigger held high ----------------
    s = start_cnt;
    exttrigger_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      I_done = (i == 4);
      tick();
    end
    I_done = 1'b0;
    exttrigger_in = 1'b0;
    tick();
    chk("trigger_level_one_launch", start_cnt - s, 1);
    chk("trigger_idle_after", O_busy, 1'b0);

    // ---------------- reset mid-RUN ----------------
    wr(A_GO, 8'd0, 8'h01);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {O_start, O_busy, O_trigger, reg_datao}, 11'd0);
    chk("midreset_O_k", O_k, '0);
    tick();
    reset_n = 1'b1;
    s = start_cnt;
    pulse_done(RX_VAL, RY_VAL);
    tick();
    chk("late_done_busy", O_busy, 1'b0);
    rd_word(A_RX, w);
    chk("late_done_rx_zero", w, '0);
    rd(A_GO, 8'd0, d);
    chk("late_done_status", d, 8'h00);

    // ---------------- operand check (K == 0 after reset) ----------------
    wr(A_GO, 8'd0, 8'h01);
`ifdef PMUL_OPERAND_CHECK_EN
    chk("zero_k_start", O_start, 1'b0);
    rd(A_GO, 8'd0, d);
    chk("zero_k_status", d, 8'h02);
`else
    chk("zero_k_start", O_start, 1'b1);
    rd(A_GO, 8'd0, d);
    chk("zero_k_status", d, 8'h01);
    pulse_done(RX_VAL, RY_VAL);
`endif
    tick();

    // ---------------- randomized phase against the model ----------------
    do_reset();
    m_k = '0; m_gx = '0; m_gy = '0; m_rx = '0; m_ry = '0;
    m_err = 1'b0; m_wwb = 1'b0;
    for (int it = 0; it < 160; it++) begin
      int         op;
      logic [7:0] a;
      int         bc;
      logic [7:0] dat;
      op  = $urandom_range(0, 7);
      a   = 8'($urandom_range(0, 9));
      bc  = $urandom_range(0, 40);
      dat = 8'($urandom_range(0, 255));
      if (op <= 3) begin
        if (a == A_GO) a = A_GX;
        wr(a, 8'(bc), dat);
        if (bc < 32) begin
          if (a == A_K)  m_k[8*bc +: 8]  = dat;
          if (a == A_GX) m_gx[8*bc +: 8] = dat;
          if (a == A_GY) m_gy[8*bc +: 8] = dat;
        end
      end else if (op <= 6) begin
        rd(a, 8'(bc), d);
        chk($sformatf("rnd%0d_read_a%0h_b%0d", it, a, bc), d, model_read(a, bc));
      end else begin
        bit refused;
        refused = 1'b0;
`ifdef PMUL_OPERAND_CHECK_EN
        refused = (m_k == '0) || ((m_gx == '0) && (m_gy == '0));
`endif
        wr(A_GO, 8'd0, dat);
        if (!dat[0]) begin
          chk($sformatf("rnd%0d_go_bit0_clear", it), O_start, 1'b0);
        end else if (refused) begin
          chk($sformatf("rnd%0d_refused", it), O_start, 1'b0);
          m_err = 1'b1;
        end else begin
          int dly;
          chk($sformatf("rnd%0d_launch", it), {O_start, O_busy}, 2'b11);
          chk($sformatf("rnd%0d_ops", it), {O_k ^ O_gx ^ O_gy}, {m_k ^ m_gx ^ m_gy});
          m_err = 1'b0;
          m_wwb = 1'b0;
          dly = $urandom_range(1, 10);
          for (int j = 0; j < dly; j++) begin
            if ($urandom_range(0, 3) == 0) begin
              wr(8'($urandom_range(1, 3)), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 255)));
              m_wwb = 1'b1;
            end else begin
              tick();
            end
          end
          w = rand256();
          m_rx = w;
          m_ry = ~w;
          pulse_done(w, ~w);
          chk($sformatf("rnd%0d_idle_after_done", it), O_busy, 1'b0);
        end
      end
    end
    chk("rnd_final_k", O_k, m_k);
    chk("rnd_final_gy", O_gy, m_gy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
